// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the fetch/data memory port arbiter.
package mem_arb_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [31:0] ARB_ABORT_DATA = 32'hDEADBEEF;

  // Bits needed to hold the values 0..max_val (never less than 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/arb_starve_counter.sv
// Saturating fetch-starvation counter; clear has priority over increment.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_limit_o
);
  localparam int W = cnt_w(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != W'(LIMIT)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign at_limit_o = (cnt_q == W'(LIMIT));
endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of one single-ported variable-latency memory.
// Optional BUSY watchdog with sticky err is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  logic [1:0]  state_q, state_d;
  logic        mem_req_q, mem_we_q, i_done_q, d_done_q;
  logic [31:0] mem_addr_q, mem_wdata_q, i_rdata_q, d_rdata_q;
  logic        i_eff, d_eff, grant_i, grant_d, starve_hit;
  logic        busy, finish, abort, end_i, end_d;

  // A port's request in its own done cycle is the tail of the served one.
  assign i_eff   = i_req & ~i_done_q;
  assign d_eff   = d_req & ~d_done_q;
  assign grant_d = (state_q == IDLE) & d_eff & ~(i_eff & starve_hit);
  assign grant_i = (state_q == IDLE) & i_eff & ~grant_d;

  assign busy   = (state_q != IDLE);
  assign finish = busy & mem_ready;
  assign end_i  = (state_q == BUSY_I) & (finish | abort);
  assign end_d  = (state_q == BUSY_D) & (finish | abort);

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (grant_d & i_req),
    .clr_i     (grant_i),
    .at_limit_o(starve_hit)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  logic [TW-1:0] wdog_q;
  logic          err_q;

  // wdog_q equals the number of BUSY cycles already completed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                wdog_q <= '0;
    else if (grant_i | grant_d) wdog_q <= '0;
    else if (busy)             wdog_q <= wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_q | abort;
  end

  assign abort = busy & ~mem_ready & (wdog_q == TW'(TIMEOUT_CYCLES - 1));
  assign err   = err_q;
`else
  assign abort = 1'b0;
  assign err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = BUSY_D;
        else if (grant_i) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: if (finish | abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_done_q <= end_i;
      d_done_q <= end_d;
      if (grant_d) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= d_we;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
      end else if (grant_i) begin
        mem_req_q   <= 1'b1;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= i_addr;
        mem_wdata_q <= '0;
      end else if (finish | abort) begin
        mem_req_q   <= 1'b0;
      end
      if (end_i) i_rdata_q <= abort ? ARB_ABORT_DATA : mem_rdata;
      if (end_d) d_rdata_q <= abort ? ARB_ABORT_DATA : (mem_we_q ? '0 : mem_rdata);
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_stall   = i_req & ~i_done_q;
  assign d_stall   = d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, i_stall, d_done, d_stall, mem_req, mem_we, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  typedef struct {
    bit          is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  exp_t        pe;
  int          total = 0, bad = 0;
  int          ws = 0, busy_cnt = 0, grants = 0, ic = 0;
  bit          mem_en = 1'b1;
  logic [31:0] rd_val = '0;
  logic        mreq_prev = 1'b0, mp = 1'b0;

  assign mem_rdata = rd_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input bit d, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e.is_d = d; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
    q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int c = 0;
    while (q.size() != 0 && c < 200) begin @(negedge clk); c++; end
    chk(tag, q.size(), 0);
  endtask

  task automatic run_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rexp);
    int c = 0;
    exp_push(1'b1, we, a, wd, rexp);
    d_we = we; d_addr = a; d_wdata = wd; d_req = 1'b1;
    do begin @(negedge clk); c++; end while (!d_done && c < 100);
    chk("run_d_done", 32'(d_done), 1);
    d_req = 1'b0;
  endtask

  // Memory model: ready after ws wait states while mem_req is high.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ready <= mem_en && (busy_cnt == ws);
      busy_cnt  <= busy_cnt + 1;
    end else begin
      mem_ready <= 1'b0;
      busy_cnt  <= 0;
    end
  end

  // Scoreboard: check each grant against the head entry, pop on done.
  always @(negedge clk) begin
    if (mem_req && !mreq_prev) begin
      grants <= grants + 1;
      chk("grant_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        chk("grant_we", 32'(mem_we), 32'(q[0].we));
        chk("grant_addr", mem_addr, q[0].addr);
        chk("grant_wdata", mem_wdata, q[0].wdata);
      end
    end
    if (i_done || d_done) begin
      chk("done_expected", 32'(q.size() != 0), 1);
      chk("done_onehot", 32'(i_done & d_done), 0);
      if (q.size() != 0) begin
        pe = q.pop_front();
        chk("done_port", 32'(d_done), 32'(pe.is_d));
        chk(pe.is_d ? "d_rdata" : "i_rdata", pe.is_d ? d_rdata : i_rdata, pe.rdata);
      end
    end
    mreq_prev <= mem_req;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", 32'({i_done, d_done}), 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);
    chk("rst_err", 32'(err), 0);
    reset = 1'b1;
    @(negedge clk);

    // 1: fetch, zero wait states
    ws = 0; rd_val = 32'h2002000A; i_addr = 32'h100; i_req = 1'b1;
    exp_push(1'b0, 1'b0, 32'h100, 32'h0, 32'h2002000A);
    #1 chk("t1_stall_c0", 32'(i_stall), 1);
    @(negedge clk);
    chk("t1_mem_req_c1", 32'(mem_req), 1);
    chk("t1_stall_c1", 32'(i_stall), 1);
    chk("t1_no_done_c1", 32'(i_done), 0);
    @(negedge clk);
    chk("t1_done_c2", 32'(i_done), 1);
    chk("t1_rdata_c2", i_rdata, 32'h2002000A);
    chk("t1_stall_c2", 32'(i_stall), 0);
    chk("t1_mem_req_c2", 32'(mem_req), 0);
    i_req = 1'b0;
    @(negedge clk);
    chk("t1_done_pulse", 32'(i_done), 0);
    chk("t1_rdata_hold", i_rdata, 32'h2002000A);

    // 2: data write, three wait states
    ws = 3; d_we = 1'b1; d_addr = 32'h54; d_wdata = 32'd7; d_req = 1'b1;
    exp_push(1'b1, 1'b1, 32'h54, 32'd7, 32'h0);
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk("t2_mem_req", 32'(mem_req), 1);
      chk("t2_mem_we", 32'(mem_we), 1);
      chk("t2_mem_wdata", mem_wdata, 32'd7);
      chk("t2_mem_addr", mem_addr, 32'h54);
      chk("t2_no_done", 32'(d_done), 0);
      @(negedge clk);
    end
    chk("t2_done", 32'(d_done), 1);
    chk("t2_rdata_write", d_rdata, 32'h0);
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0; ws = 0;
    @(negedge clk);

    // 3: both contending; fetch is idle in each d_done cycle so starvation builds
    rd_val = 32'h0BADF00D; i_addr = 32'h1000; d_addr = 32'h2000;
    for (int k = 0; k < 10; k++)
      exp_push((k % 5) != 4, 1'b0, ((k % 5) != 4) ? 32'h2000 : 32'h1000, 32'h0, 32'h0BADF00D);
    ic = 0; mp = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      i_req = !d_done;
      if (mem_req && !mp && mem_addr == 32'h1000) ic++;
      mp = mem_req;
      if (ic == 2) break;
    end
    d_req = 1'b0;
    for (int c = 0; c < 20 && !i_done; c++) @(negedge clk);
    i_req = 1'b0;
    drain("t3_drain");

    // 6: data request arrives in the i_done cycle
    ws = 1; rd_val = 32'h600D0006; i_addr = 32'h300; i_req = 1'b1;
    exp_push(1'b0, 1'b0, 32'h300, 32'h0, 32'h600D0006);
    exp_push(1'b1, 1'b0, 32'h400, 32'h0, 32'h600D0006);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i_done) break;
    end
    chk("t6_i_done", 32'(i_done), 1);
    d_addr = 32'h400; d_we = 1'b0; d_req = 1'b1;
    @(negedge clk);
    chk("t6_d_granted", mem_addr, 32'h400);
    i_req = 1'b0;
    for (int c = 0; c < 20 && !d_done; c++) @(negedge clk);
    d_req = 1'b0;
    drain("t6_drain");
    @(negedge clk);

    // 4: reset in the middle of BUSY_D
    ws = 0; mem_en = 1'b0; d_addr = 32'h80; d_req = 1'b1;
    exp_push(1'b1, 1'b0, 32'h80, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("t4_busy", 32'(mem_req), 1);
    reset = 1'b0;
    #1 chk("t4_mem_req_async", 32'(mem_req), 0);
    q.delete(); d_req = 1'b0;
    @(negedge clk);
    chk("t4_no_done_rst", 32'(d_done), 0);
    reset = 1'b1; mem_en = 1'b1;
    @(negedge clk);
    chk("t4_no_done_rel", 32'(d_done), 0);
    rd_val = 32'h44;
    run_d(1'b0, 32'h84, 32'h0, 32'h44);
    drain("t4_drain");

`ifdef MEM_ARB_TIMEOUT_EN
    // 5: watchdog abort after 8 BUSY cycles
    mem_en = 1'b0; d_addr = 32'h90; d_req = 1'b1;
    exp_push(1'b1, 1'b0, 32'h90, 32'h0, 32'hDEADBEEF);
    @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      chk("t5_busy", 32'(mem_req), 1);
      chk("t5_no_done", 32'(d_done), 0);
      @(negedge clk);
    end
    chk("t5_abort_done", 32'(d_done), 1);
    chk("t5_abort_data", d_rdata, 32'hDEADBEEF);
    chk("t5_err_set", 32'(err), 1);
    chk("t5_mem_req_clr", 32'(mem_req), 0);
    d_req = 1'b0; mem_en = 1'b1;
    @(negedge clk);
    run_d(1'b0, 32'h94, 32'h0, 32'h44);
    chk("t5_err_sticky", 32'(err), 1);
    reset = 1'b0;
    #1 chk("t5_err_rst", 32'(err), 0);
    @(negedge clk);
    reset = 1'b1;
`else
    // 5: no watchdog, BUSY waits indefinitely
    mem_en = 1'b0; d_addr = 32'h90; d_req = 1'b1;
    exp_push(1'b1, 1'b0, 32'h90, 32'h0, 32'h0);
    repeat (100) @(negedge clk);
    chk("t5_still_busy", 32'(mem_req), 1);
    chk("t5_no_done", 32'(d_done), 0);
    chk("t5_err_zero", 32'(err), 0);
    reset = 1'b0;
    q.delete(); d_req = 1'b0;
    #1 chk("t5_mem_req_rst", 32'(mem_req), 0);
    @(negedge clk);
    reset = 1'b1; mem_en = 1'b1;
`endif
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
